// File: rtl/pipe_mask_decoder.sv
// Pipelined N-bit index decoder producing one-hot, thermometer or inverted one-hot masks.
// Predecodes the upper/lower index halves in stage 1 and combines them in the last stage.
module pipe_mask_decoder #(
  parameter int N      = 5,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      x,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2**N-1:0]   y
);

  localparam int L  = N / 2;
  localparam int H  = N - L;
  localparam int W  = 1 << N;
  localparam int WU = 1 << H;
  localparam int WV = 1 << L;
  localparam logic [N-1:0] LO_MASK = N'((1 << L) - 1);

  typedef struct packed {
    logic [1:0]    mode;
    logic [WU-1:0] u;
    logic [WU-1:0] ul;
    logic [WV-1:0] v;
    logic [WV-1:0] vl;
  } pre_t;

  logic [N-1:0]      xHi, xLo;
  logic [WU-1:0]     uIn, ulIn;
  logic [WV-1:0]     vIn, vlIn;
  pre_t              preIn_d;
  pre_t              lastPre;
  logic [W-1:0]      y_d, y_q;
  logic [STAGES:1]   v_q, v_d, upValid;
  logic [STAGES+1:1] load;

  // With L = 0 the lower half is empty: xLo is forced to 0 and V/Vl collapse to a single 1.
  assign xHi = x >> L;
  assign xLo = x & LO_MASK;

  for (genvar j = 0; j < WU; j++) begin : g_hi
    assign uIn[j]  = (xHi == N'(j));
    assign ulIn[j] = (N'(j) <= xHi);
  end

  for (genvar j = 0; j < WV; j++) begin : g_lo
    assign vIn[j]  = (xLo == N'(j));
    assign vlIn[j] = (N'(j) <= xLo);
  end

  assign preIn_d = {mode, uIn, ulIn, vIn, vlIn};

  for (genvar a = 0; a < WU; a++) begin : g_ca
    for (genvar b = 0; b < WV; b++) begin : g_cb
      logic oh, tl;
      assign oh = lastPre.u[a] & lastPre.v[b];
      assign tl = (lastPre.ul[a] & ~lastPre.u[a]) | (lastPre.u[a] & lastPre.vl[b]);
      assign y_d[a*WV+b] = (lastPre.mode == 2'b00) ? oh :
                           (lastPre.mode == 2'b01) ? tl :
                           (lastPre.mode == 2'b10) ? (~tl | oh) : ~oh;
    end
  end

  // A stage may load when it, or every stage downstream of it, can drain this cycle.
  assign load[STAGES+1] = out_ready;
  assign upValid[1]     = in_valid;
  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    assign load[k] = out_ready | ~(&v_q[STAGES:k]);
    assign v_d[k]  = load[k] ? upValid[k] : v_q[k];
    if (k > 1) begin : g_up
      assign upValid[k] = v_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) v_q <= '0;
    else     v_q <= v_d;
  end

  if (STAGES == 1) begin : g_s1
    assign lastPre = preIn_d;
  end else begin : g_sn
    pre_t pre1_q;

    always_ff @(posedge clk) begin
      if (rst)                       pre1_q <= '0;
      else if (load[1] && in_valid)  pre1_q <= preIn_d;
    end

    if (STAGES == 3) begin : g_s3
      pre_t pre2_q;

      always_ff @(posedge clk) begin
        if (rst)                     pre2_q <= '0;
        else if (load[2] && v_q[1])  pre2_q <= pre1_q;
      end

      assign lastPre = pre2_q;
    end else begin : g_s2
      assign lastPre = pre1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                  y_q <= '0;
    else if (load[STAGES] && upValid[STAGES]) y_q <= y_d;
  end

  assign in_ready  = load[1] & ~rst;
  assign out_valid = v_q[STAGES];
  assign y         = y_q;

endmodule

// File: tb/tb_pipe_mask_decoder.sv
// Directed and swept checks of pipe_mask_decoder across several N/STAGES configurations.
// One shared stimulus set drives whichever instance is selected by 'sel'.
module tb_pipe_mask_decoder;

  logic         clk = 1'b0;
  logic         rst;
  logic         inValid;
  logic         outReady;
  logic [7:0]   x;
  logic [1:0]   mode;
  int           sel;
  int           vecCount = 0;
  int           errCount = 0;

  logic         r0, v0, r1, v1, r2, v2, r3, v3;
  logic [31:0]  y0;
  logic [7:0]   y1;
  logic [255:0] y2;
  logic [1:0]   y3;
  logic         obsReady, obsValid;
  logic [255:0] obsY;

  always #5 clk = ~clk;

  pipe_mask_decoder #(.N(5), .STAGES(2)) dutMain (
    .clk(clk), .rst(rst), .in_valid(inValid && sel == 0), .in_ready(r0),
    .x(x[4:0]), .mode(mode), .out_valid(v0), .out_ready(outReady), .y(y0));

  pipe_mask_decoder #(.N(3), .STAGES(3)) dutN3 (
    .clk(clk), .rst(rst), .in_valid(inValid && sel == 1), .in_ready(r1),
    .x(x[2:0]), .mode(mode), .out_valid(v1), .out_ready(outReady), .y(y1));

  pipe_mask_decoder #(.N(8), .STAGES(1)) dutN8 (
    .clk(clk), .rst(rst), .in_valid(inValid && sel == 2), .in_ready(r2),
    .x(x), .mode(mode), .out_valid(v2), .out_ready(outReady), .y(y2));

  pipe_mask_decoder #(.N(1), .STAGES(3)) dutN1 (
    .clk(clk), .rst(rst), .in_valid(inValid && sel == 3), .in_ready(r3),
    .x(x[0:0]), .mode(mode), .out_valid(v3), .out_ready(outReady), .y(y3));

  always_comb begin
    obsReady = 1'b0;
    obsValid = 1'b0;
    obsY     = '0;
    case (sel)
      0: begin obsReady = r0; obsValid = v0; obsY[31:0] = y0; end
      1: begin obsReady = r1; obsValid = v1; obsY[7:0]  = y1; end
      2: begin obsReady = r2; obsValid = v2; obsY       = y2; end
      default: begin obsReady = r3; obsValid = v3; obsY[1:0] = y3; end
    endcase
  end

  function automatic logic [255:0] refMask(input logic [7:0] xv, input logic [1:0] m, input int n);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < (1 << n); i++) begin
      case (m)
        2'b00:   r[i] = (i == int'(xv));
        2'b01:   r[i] = (i <= int'(xv));
        2'b10:   r[i] = (i >= int'(xv));
        default: r[i] = (i != int'(xv));
      endcase
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One beat with out_ready high: nothing visible after one cycle, result after two.
  task automatic applyStimulus(input string tag, input logic [7:0] xv, input logic [1:0] m,
                               input logic [255:0] exp);
    @(negedge clk);
    inValid = 1'b1; x = xv; mode = m; outReady = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    #1 checkOutput({tag, "-lat"}, 256'(obsValid), 256'(0));
    @(negedge clk);
    #1 checkOutput({tag, "-valid"}, 256'(obsValid), 256'(1));
    checkOutput(tag, obsY, exp);
  endtask

  // Streams every (x, mode) pair into the selected instance under random backpressure.
  task automatic runSweep(input int s, input int n);
    logic [255:0] q[$];
    int total, sent, got, cycles;
    total = 4 << n; sent = 0; got = 0; cycles = 0;
    @(negedge clk);
    sel = s;
    while (got < total && cycles < 4 * total + 50) begin
      @(negedge clk);
      inValid  = (sent < total);
      x        = 8'(sent >> 2);
      mode     = 2'(sent & 3);
      outReady = 1'($urandom_range(0, 1));
      #1;
      if (obsValid && outReady) begin
        if (q.size() == 0) checkOutput($sformatf("sweep-N%0d-spurious", n), 256'(obsValid), 256'(0));
        else               checkOutput($sformatf("sweep-N%0d", n), obsY, q.pop_front());
        got++;
      end
      if (inValid && obsReady) begin
        q.push_back(refMask(x, mode, n));
        sent++;
      end
      cycles++;
    end
    inValid = 1'b0;
    if (got < total) checkOutput($sformatf("sweep-N%0d-timeout", n), 256'(got), 256'(total));
  endtask

  initial begin
    rst = 1'b1; inValid = 1'b0; outReady = 1'b0; x = '0; mode = '0; sel = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 checkOutput("rst-valid", 256'(obsValid), 256'(0));
    checkOutput("rst-y", obsY, 256'(0));
    checkOutput("rst-ready", 256'(obsReady), 256'(0));
    rst = 1'b0;
    #1 checkOutput("rst-ready-after", 256'(obsReady), 256'(1));

    applyStimulus("x5-onehot", 8'd5, 2'b00, 256'h0000_0020);
    applyStimulus("x5-thlo",   8'd5, 2'b01, 256'h0000_003F);
    applyStimulus("x5-thhi",   8'd5, 2'b10, 256'hFFFF_FFE0);
    applyStimulus("x5-inv",    8'd5, 2'b11, 256'hFFFF_FFDF);
    applyStimulus("x0-thlo",   8'd0, 2'b01, 256'h0000_0001);
    applyStimulus("x0-thhi",   8'd0, 2'b10, 256'hFFFF_FFFF);
    applyStimulus("x31-thlo",  8'd31, 2'b01, 256'hFFFF_FFFF);
    applyStimulus("x31-thhi",  8'd31, 2'b10, 256'h8000_0000);

    // Backpressure: two beats fill the pipe, the third waits until the consumer resumes.
    @(negedge clk);
    outReady = 1'b0; inValid = 1'b1; x = 8'd1; mode = 2'b00;
    #1 checkOutput("bp-rdy1", 256'(obsReady), 256'(1));
    @(negedge clk);
    x = 8'd2;
    #1 checkOutput("bp-rdy2", 256'(obsReady), 256'(1));
    @(negedge clk);
    x = 8'd3;
    #1 checkOutput("bp-full", 256'(obsReady), 256'(0));
    checkOutput("bp-valid", 256'(obsValid), 256'(1));
    checkOutput("bp-y", obsY, 256'h2);
    @(negedge clk);
    #1 checkOutput("bp-hold-y", obsY, 256'h2);
    checkOutput("bp-hold-rdy", 256'(obsReady), 256'(0));
    @(negedge clk);
    outReady = 1'b1;
    #1 checkOutput("bp-rdy3", 256'(obsReady), 256'(1));
    checkOutput("bp-out1", obsY, 256'h2);
    @(negedge clk);
    inValid = 1'b0;
    #1 checkOutput("bp-out2-valid", 256'(obsValid), 256'(1));
    checkOutput("bp-out2", obsY, 256'h4);
    @(negedge clk);
    #1 checkOutput("bp-out3-valid", 256'(obsValid), 256'(1));
    checkOutput("bp-out3", obsY, 256'h8);
    @(negedge clk);
    #1 checkOutput("bp-empty", 256'(obsValid), 256'(0));

    // Bubble collapse: a stalled single beat leaves room for a second one.
    @(negedge clk);
    outReady = 1'b0; inValid = 1'b1; x = 8'd9; mode = 2'b00;
    @(negedge clk);
    inValid = 1'b0;
    @(negedge clk);
    #1 checkOutput("bc-first", obsY, 256'h200);
    checkOutput("bc-first-valid", 256'(obsValid), 256'(1));
    @(negedge clk);
    #1 checkOutput("bc-hold", obsY, 256'h200);
    @(negedge clk);
    inValid = 1'b1; x = 8'd10;
    #1 checkOutput("bc-rdy", 256'(obsReady), 256'(1));
    @(negedge clk);
    inValid = 1'b0; outReady = 1'b1;
    #1 checkOutput("bc-out1", obsY, 256'h200);
    @(negedge clk);
    #1 checkOutput("bc-out2-valid", 256'(obsValid), 256'(1));
    checkOutput("bc-out2", obsY, 256'h400);
    @(negedge clk);
    #1 checkOutput("bc-empty", 256'(obsValid), 256'(0));

    // Reset with two beats in flight must flush them.
    @(negedge clk);
    outReady = 1'b0; inValid = 1'b1; x = 8'd1; mode = 2'b00;
    @(negedge clk);
    x = 8'd2;
    @(negedge clk);
    inValid = 1'b0; rst = 1'b1;
    #1 checkOutput("rs-rdy", 256'(obsReady), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("rs-valid", 256'(obsValid), 256'(0));
    checkOutput("rs-y", obsY, 256'(0));
    applyStimulus("rs-new", 8'd7, 2'b00, 256'h80);

    runSweep(0, 5);
    runSweep(1, 3);
    runSweep(2, 8);
    runSweep(3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
